// File: rtl/i2c_tx_fifo_if.sv
// Bus between the APB bridge (master) and the TX FIFO (slave).
// It carries push/pop strobes, data, status and error flags.
interface i2c_tx_fifo_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 4
);
  logic              WR_EN;
  logic [DWIDTH-1:0] DATA_IN;
  logic              RD_EN;
  logic              CLEAR_ERR;
  logic [DWIDTH-1:0] DATA_OUT;
  logic              EMPTY;
  logic              FULL;
  logic              ALMOST_FULL;
  logic [AWIDTH:0]   LEVEL;
  logic              OVERFLOW;
  logic              UNDERFLOW;

  modport master (
    output WR_EN, DATA_IN, RD_EN, CLEAR_ERR,
    input  DATA_OUT, EMPTY, FULL, ALMOST_FULL, LEVEL, OVERFLOW, UNDERFLOW
  );

  modport slave (
    input  WR_EN, DATA_IN, RD_EN, CLEAR_ERR,
    output DATA_OUT, EMPTY, FULL, ALMOST_FULL, LEVEL, OVERFLOW, UNDERFLOW
  );
endinterface

// File: rtl/i2c_tx_fifo.sv
// First-word-fall-through TX FIFO between the APB bridge and the I2C core.
// Status is decoded from a registered occupancy counter; error flags are sticky.
module i2c_tx_fifo #(
  parameter int DWIDTH   = 32,
  parameter int DEPTH    = 16,
  parameter int AWIDTH   = 4,
  parameter int AF_LEVEL = 12
) (
  input  logic           PCLK,
  input  logic           PRESET,
  i2c_tx_fifo_if.slave   bus
);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   level_q, level_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic empty, full, push, pop;

  assign empty = (level_q == '0);
  assign full  = (level_q == (AWIDTH+1)'(DEPTH));
  assign pop   = bus.RD_EN & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push  = bus.WR_EN & (~full | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + AWIDTH'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AWIDTH'(1);
    if (push && !pop)      level_d = level_q + (AWIDTH+1)'(1);
    else if (pop && !push) level_d = level_q - (AWIDTH+1)'(1);
    // A new error event takes priority over a same-cycle clear.
    ovf_d = (ovf_q & ~bus.CLEAR_ERR) | (bus.WR_EN & ~push);
    unf_d = (unf_q & ~bus.CLEAR_ERR) | (bus.RD_EN & empty);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge PCLK) begin
    if (!PRESET && push) mem_q[wr_ptr_q] <= bus.DATA_IN;
  end

  assign bus.DATA_OUT    = mem_q[rd_ptr_q];
  assign bus.EMPTY       = empty;
  assign bus.FULL        = full;
  assign bus.ALMOST_FULL = (level_q >= (AWIDTH+1)'(AF_LEVEL));
  assign bus.LEVEL       = level_q;
  assign bus.OVERFLOW    = ovf_q;
  assign bus.UNDERFLOW   = unf_q;

endmodule

// File: tb/tb_i2c_tx_fifo.sv
// Bench for i2c_tx_fifo: directed scenarios plus randomized traffic,
// all compared against a queue-based reference model.
module tb_i2c_tx_fifo;
  localparam int DW = 32, DEPTH = 16, AW = 4, AFL = 12;

  logic PCLK = 1'b0;
  logic PRESET;
  int   n_chk = 0, n_err = 0;

  i2c_tx_fifo_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

  i2c_tx_fifo #(.DWIDTH(DW), .DEPTH(DEPTH), .AWIDTH(AW), .AF_LEVEL(AFL)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  always #5 PCLK = ~PCLK;

  // Reference model: the FIFO contents as a queue plus two sticky bits.
  logic [DW-1:0] mq[$];
  bit m_ovf, m_unf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("level", 64'(bus.LEVEL), 64'(mq.size()));
    chk("empty", 64'(bus.EMPTY), 64'(mq.size() == 0));
    chk("full", 64'(bus.FULL), 64'(mq.size() == DEPTH));
    chk("almost_full", 64'(bus.ALMOST_FULL), 64'(mq.size() >= AFL));
    chk("overflow", 64'(bus.OVERFLOW), 64'(m_ovf));
    chk("underflow", 64'(bus.UNDERFLOW), 64'(m_unf));
    if (mq.size() != 0) chk("data_out", 64'(bus.DATA_OUT), 64'(mq[0]));
  endtask

  // Apply one cycle of inputs, advance the model, then compare.
  task automatic cyc(input bit wr, input logic [DW-1:0] din, input bit rd,
                     input bit clr, input bit rst);
    bit was_empty, was_full, do_pop, do_push;
    bus.WR_EN = wr; bus.DATA_IN = din; bus.RD_EN = rd;
    bus.CLEAR_ERR = clr; PRESET = rst;
    @(posedge PCLK);
    #1;
    if (rst) begin
      mq.delete(); m_ovf = 0; m_unf = 0;
    end else begin
      was_empty = (mq.size() == 0);
      was_full  = (mq.size() == DEPTH);
      do_pop    = rd && !was_empty;
      do_push   = wr && (!was_full || do_pop);
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(din);
      m_ovf = (wr && !do_push) || (m_ovf && !clr);
      m_unf = (rd && was_empty) || (m_unf && !clr);
    end
    bus.WR_EN = 0; bus.RD_EN = 0; bus.CLEAR_ERR = 0; PRESET = 0;
    check_all();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.WR_EN = 0; bus.RD_EN = 0; bus.CLEAR_ERR = 0; bus.DATA_IN = '0; PRESET = 1;

    // Reset then idle
    cyc(0, 0, 0, 0, 1);
    chk("rst_empty", 64'(bus.EMPTY), 64'd1);
    chk("rst_level", 64'(bus.LEVEL), 64'd0);
    cyc(0, 0, 0, 0, 0);

    // Single word, fall-through
    cyc(1, 32'hA5A5_0001, 0, 0, 0);
    chk("fwft_data", 64'(bus.DATA_OUT), 64'hA5A5_0001);
    chk("fwft_level", 64'(bus.LEVEL), 64'd1);
    cyc(0, 0, 1, 0, 0);
    chk("pop_empty", 64'(bus.EMPTY), 64'd1);

    // Fill, overflow, drain in order
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, 32'h100 + i, 0, 0, 0);
      if (i == AFL - 2) chk("af_before", 64'(bus.ALMOST_FULL), 64'd0);
      if (i == AFL - 1) chk("af_at", 64'(bus.ALMOST_FULL), 64'd1);
    end
    chk("fill_full", 64'(bus.FULL), 64'd1);
    cyc(1, 32'hDEAD, 0, 0, 0);
    chk("ovf_set", 64'(bus.OVERFLOW), 64'd1);
    chk("ovf_level", 64'(bus.LEVEL), 64'd16);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_order", 64'(bus.DATA_OUT), 64'(32'h100 + i));
      cyc(0, 0, 1, 0, 0);
    end
    cyc(0, 0, 0, 1, 0);
    chk("ovf_clr", 64'(bus.OVERFLOW), 64'd0);

    // Full push+pop, then drain across the pointer wrap
    for (int i = 0; i < DEPTH; i++) cyc(1, 32'h100 + i, 0, 0, 0);
    cyc(1, 32'h200, 1, 0, 0);
    chk("fullrw_level", 64'(bus.LEVEL), 64'd16);
    chk("fullrw_ovf", 64'(bus.OVERFLOW), 64'd0);
    for (int i = 1; i <= DEPTH; i++) begin
      chk("wrap_order", 64'(bus.DATA_OUT), (i == DEPTH) ? 64'h200 : 64'(32'h100 + i));
      cyc(0, 0, 1, 0, 0);
    end

    // Underflow and clear semantics
    cyc(0, 0, 1, 0, 0);
    chk("unf_set", 64'(bus.UNDERFLOW), 64'd1);
    cyc(0, 0, 0, 1, 0);
    chk("unf_clr", 64'(bus.UNDERFLOW), 64'd0);
    cyc(0, 0, 1, 1, 0);
    chk("unf_clr_vs_event", 64'(bus.UNDERFLOW), 64'd1);
    cyc(1, 32'h77, 1, 1, 0);
    chk("empty_wr_rd_level", 64'(bus.LEVEL), 64'd1);
    chk("empty_wr_rd_unf", 64'(bus.UNDERFLOW), 64'd1);
    cyc(0, 0, 1, 1, 0);

    // Reset mid-operation with a concurrent push
    for (int i = 0; i < 3; i++) cyc(1, 32'h300 + i, 0, 0, 0);
    cyc(1, 32'h3FF, 0, 0, 1);
    chk("midrst_level", 64'(bus.LEVEL), 64'd0);
    chk("midrst_empty", 64'(bus.EMPTY), 64'd1);
    cyc(0, 0, 0, 0, 0);

    // Randomized traffic in phases of varying push/pop bias
    for (int ph = 0; ph < 40; ph++) begin
      int wp, rp;
      wp = $urandom_range(10, 90);
      rp = $urandom_range(10, 90);
      for (int c = 0; c < 60; c++) begin
        cyc($urandom_range(0, 99) < wp, $urandom, $urandom_range(0, 99) < rp,
            $urandom_range(0, 19) == 0, $urandom_range(0, 299) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
